// File: rtl/rx_supervisor.sv
// rx_supervisor: receiver watchdog that pulses receiver_rst on length, DC-bias or busy-timeout faults.
// Define RX_SUPERVISOR_TIMEOUT_EN to build the busy-timeout detector.
module rx_supervisor #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int N_CH          = 2,
    parameter int WIN_LOG2      = 4,
    parameter int RST_LEN       = 8,
    parameter int HOLDOFF_LEN   = 64
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [2*IQ_DATA_WIDTH*N_CH-1:0] sample_in,
    input  logic                            sample_in_strobe,
    input  logic [N_CH-1:0]                 ch_mask,
    input  logic                            demod_is_ongoing,
    input  logic                            sig_valid,
    input  logic [15:0]                     signal_len,
    input  logic [15:0]                     max_signal_len_th,
    input  logic [7:0]                      dc_running_sum_th,
    input  logic [23:0]                     demod_timeout_th,
    output logic                            receiver_rst,
    output logic [2:0]                      rst_cause,
    output logic [15:0]                     rst_count
);
    localparam int W    = IQ_DATA_WIDTH;
    localparam int AW   = WIN_LOG2 + 2;
    localparam int PMAX = (RST_LEN > HOLDOFF_LEN) ? RST_LEN : HOLDOFF_LEN;
    localparam int CW   = $clog2(PMAX + 1);

    localparam logic [CW-1:0]       PH_ONE    = CW'(1);
    localparam logic [CW-1:0]       RST_LAST  = CW'(RST_LEN - 1);
    localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLDOFF_LEN - 1);
    localparam logic [WIN_LOG2-1:0] WIN_ONE   = WIN_LOG2'(1);
    localparam logic [AW-1:0]       ACC_ONE   = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLDOFF
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_phase, w_phase_nxt;
    logic [WIN_LOG2-1:0] r_win;
    logic [AW-1:0]       r_acc_i [N_CH];
    logic [AW-1:0]       r_acc_q [N_CH];
    logic [AW-1:0]       w_sum_i [N_CH];
    logic [AW-1:0]       w_sum_q [N_CH];
    logic [N_CH-1:0]     w_flag;
    logic                w_win_end, w_dc_clr;
    logic                w_len_trig, w_dc_trig, w_to_trig;
    logic [2:0]          w_trig;
    logic                w_fire;
    logic                w_unused_bits;

    // Per-channel sign accumulation; only the sign bit of each component matters.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic          w_neg_i, w_neg_q;
        logic [AW-1:0] w_abs_i, w_abs_q;
        assign w_neg_i = sample_in[k*2*W + 2*W - 1];
        assign w_neg_q = sample_in[k*2*W + W - 1];
        assign w_sum_i[k] = w_neg_i ? r_acc_i[k] - ACC_ONE
                                    : r_acc_i[k] + ACC_ONE;
        assign w_sum_q[k] = w_neg_q ? r_acc_q[k] - ACC_ONE
                                    : r_acc_q[k] + ACC_ONE;
        assign w_abs_i = w_sum_i[k][AW-1] ? -w_sum_i[k] : w_sum_i[k];
        assign w_abs_q = w_sum_q[k][AW-1] ? -w_sum_q[k] : w_sum_q[k];
        assign w_flag[k] = (32'(w_abs_i) >= 32'(dc_running_sum_th))
                        || (32'(w_abs_q) >= 32'(dc_running_sum_th));
    end

    assign w_dc_clr  = demod_is_ongoing || (r_state != IDLE);
    assign w_win_end = sample_in_strobe && (r_win == '1);

    assign w_len_trig = sig_valid && (max_signal_len_th != '0)
                     && (signal_len > max_signal_len_th);

    assign w_dc_trig = w_win_end && !w_dc_clr
                    && (dc_running_sum_th != '0)
                    && (ch_mask != '0)
                    && ((w_flag & ch_mask) == ch_mask);

`ifdef RX_SUPERVISOR_TIMEOUT_EN
    logic [23:0] r_busy, w_busy_inc;
    // w_busy_inc is the busy count including the current cycle.
    assign w_busy_inc = r_busy + 24'd1;
    assign w_to_trig  = demod_is_ongoing && (demod_timeout_th != '0)
                     && (w_busy_inc == demod_timeout_th);
    assign w_unused_bits = ^sample_in;

    // Busy-cycle counter; restarts on pulse entry and whenever demod is idle.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_busy <= '0;
        end else if (w_fire || !demod_is_ongoing) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_inc;
        end
    end
`else
    assign w_to_trig     = 1'b0;
    assign w_unused_bits = ^{sample_in, demod_timeout_th};
`endif

    assign w_trig = {w_to_trig, w_dc_trig, w_len_trig};
    assign w_fire = (r_state == IDLE) && (w_trig != 3'b000);

    // DC window: accumulate strobes while idle, restart at window end.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_win <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_acc_i[k] <= '0;
                r_acc_q[k] <= '0;
            end
        end else if (w_dc_clr || w_win_end) begin
            r_win <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_acc_i[k] <= '0;
                r_acc_q[k] <= '0;
            end
        end else if (sample_in_strobe) begin
            r_win <= r_win + WIN_ONE;
            for (int k = 0; k < N_CH; k++) begin
                r_acc_i[k] <= w_sum_i[k];
                r_acc_q[k] <= w_sum_q[k];
            end
        end
    end

    // Next-state logic: IDLE -> PULSE -> HOLDOFF -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        unique case (r_state)
            IDLE: begin
                if (w_fire) begin
                    w_state_nxt = PULSE;
                    w_phase_nxt = '0;
                end
            end
            PULSE: begin
                if (r_phase == RST_LAST) begin
                    w_state_nxt = HOLDOFF;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_ONE;
                end
            end
            HOLDOFF: begin
                if (r_phase == HOLD_LAST) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // State, pulse output, cause latch and saturating pulse counter.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            receiver_rst <= 1'b0;
            rst_cause    <= '0;
            rst_count    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            receiver_rst <= (w_state_nxt == PULSE);
            rst_cause    <= w_fire ? w_trig : rst_cause;
            rst_count    <= (w_fire && rst_count != 16'hFFFF)
                            ? rst_count + 16'd1 : rst_count;
        end
    end
endmodule

// File: tb/tb_rx_supervisor.sv
// tb_rx_supervisor: table, directed and random checks of rx_supervisor
// against a cycle-count reference model.
module tb_rx_supervisor;
    localparam int W   = 16;
    localparam int NCH = 2;
    localparam int WL  = 4;
    localparam int RL  = 8;
    localparam int HL  = 64;
    localparam int WIN = 1 << WL;

    logic                 clk;
    logic                 rstn;
    logic [2*W*NCH-1:0]   sample_in;
    logic                 strobe;
    logic [NCH-1:0]       mask;
    logic                 busy;
    logic                 sig_valid;
    logic [15:0]          slen;
    logic [15:0]          max_th;
    logic [7:0]           dc_th;
    logic [23:0]          to_th;
    logic                 rrst;
    logic [2:0]           cause;
    logic [15:0]          cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rx_supervisor #(
        .IQ_DATA_WIDTH(W),
        .N_CH(NCH),
        .WIN_LOG2(WL),
        .RST_LEN(RL),
        .HOLDOFF_LEN(HL)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rstn),
        .sample_in(sample_in),
        .sample_in_strobe(strobe),
        .ch_mask(mask),
        .demod_is_ongoing(busy),
        .sig_valid(sig_valid),
        .signal_len(slen),
        .max_signal_len_th(max_th),
        .dc_running_sum_th(dc_th),
        .demod_timeout_th(to_th),
        .receiver_rst(rrst),
        .rst_cause(cause),
        .rst_count(cnt)
    );

    int total = 0;
    int bad   = 0;

    int si [NCH];
    int sq [NCH];

    int         m_left;
    int         m_cnt;
    int         m_busy;
    int         m_nstb;
    logic [2:0] m_cause;
    int         m_si [NCH];
    int         m_sq [NCH];

    typedef struct {
        logic [15:0] len;
        logic [15:0] th;
        logic        v;
        logic        exp;
    } lvec_t;
    lvec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic clr_dc();
        m_nstb = 0;
        for (int k = 0; k < NCH; k++) begin
            m_si[k] = 0;
            m_sq[k] = 0;
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_cnt   = 0;
        m_busy  = 0;
        m_cause = 3'b000;
        clr_dc();
    endtask

    task automatic pack();
        for (int k = 0; k < NCH; k++) begin
            sample_in[k*2*W + W +: W] = 16'(si[k]);
            sample_in[k*2*W +: W]     = 16'(sq[k]);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One clock: predict from current inputs, advance, compare outputs.
    task automatic step();
        logic [2:0] t;
        bit         idle;
        bit         all;
        int         nb;
        pack();
        idle = (m_left == 0);
        t    = 3'b000;
        if (sig_valid && max_th != 0 && int'(slen) > int'(max_th))
            t[0] = 1'b1;
        if (!idle || busy) begin
            clr_dc();
        end else if (strobe) begin
            for (int k = 0; k < NCH; k++) begin
                m_si[k] += (si[k] >= 0) ? 1 : -1;
                m_sq[k] += (sq[k] >= 0) ? 1 : -1;
            end
            m_nstb++;
            if (m_nstb == WIN) begin
                all = 1;
                for (int k = 0; k < NCH; k++)
                    if (mask[k] && iabs(m_si[k]) < int'(dc_th)
                                && iabs(m_sq[k]) < int'(dc_th))
                        all = 0;
                if (dc_th != 0 && mask != 0 && all) t[1] = 1'b1;
                clr_dc();
            end
        end
        nb = busy ? (m_busy + 1) % (1 << 24) : 0;
`ifdef RX_SUPERVISOR_TIMEOUT_EN
        if (busy && to_th != 0 && nb == int'(to_th)) t[2] = 1'b1;
`endif
        if (idle && t != 3'b000) begin
            m_left  = RL + HL;
            m_cause = t;
            if (m_cnt < 65535) m_cnt++;
            m_busy  = 0;
        end else begin
            if (m_left > 0) m_left--;
            m_busy = nb;
        end
        @(posedge clk);
        #1;
        chk("rst", 32'(rrst), 32'(m_left > HL));
        chk("cause", 32'(cause), 32'(m_cause));
        chk("count", 32'(cnt), 32'(m_cnt));
    endtask

    task automatic quiet();
        strobe    = 1'b0;
        sig_valid = 1'b0;
        busy      = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            si[k] = 0;
            sq[k] = 0;
        end
    endtask

    task automatic settle();
        repeat (RL + HL + 2) step();
    endtask

    task automatic dc_window(input bit alt1, input bit len_too);
        strobe = 1'b1;
        for (int n = 0; n < WIN; n++) begin
            si[0] = 5;
            sq[0] = -3;
            si[1] = alt1 ? ((n % 2 == 0) ? 1 : -1) : 5;
            sq[1] = alt1 ? ((n % 2 == 0) ? -1 : 1) : -3;
            if (len_too && n == WIN - 1) begin
                sig_valid = 1'b1;
                slen      = 16'd1001;
                max_th    = 16'd1000;
            end
            step();
            sig_valid = 1'b0;
        end
        strobe = 1'b0;
    endtask

    int  hold_cnt;
    bit  saw;
    int  bi [NCH];
    int  bq [NCH];

    initial begin
        tbl[0] = '{16'd1001,  16'd1000,  1'b1, 1'b1};
        tbl[1] = '{16'd1000,  16'd1000,  1'b1, 1'b0};
        tbl[2] = '{16'd999,   16'd1000,  1'b1, 1'b0};
        tbl[3] = '{16'd5000,  16'd0,     1'b1, 1'b0};
        tbl[4] = '{16'hFFFF,  16'hFFFE,  1'b1, 1'b1};
        tbl[5] = '{16'd2000,  16'd1000,  1'b0, 1'b0};
        tbl[6] = '{16'd1,     16'd0,     1'b1, 1'b0};
        tbl[7] = '{16'h8000,  16'h7FFF,  1'b1, 1'b1};

        rstn      = 1'b0;
        sample_in = '0;
        mask      = '0;
        slen      = '0;
        max_th    = '0;
        dc_th     = '0;
        to_th     = '0;
        quiet();
        model_reset();
        pack();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rst", 32'(rrst), 32'd0);
        chk("reset_cause", 32'(cause), 32'd0);
        chk("reset_count", 32'(cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) step();

        // Length trigger: exact latency and width.
        slen      = 16'd1001;
        max_th    = 16'd1000;
        sig_valid = 1'b1;
        step();
        sig_valid = 1'b0;
        chk("len_latency", 32'(rrst), 32'd1);
        for (int i = 2; i <= 10; i++) begin
            step();
            chk("len_width", 32'(rrst), 32'(i <= RL));
        end
        chk("len_cause", 32'(cause), 32'b001);
        chk("len_count", 32'(cnt), 32'd1);
        settle();

        // Length threshold table.
        foreach (tbl[i]) begin
            slen      = tbl[i].len;
            max_th    = tbl[i].th;
            sig_valid = tbl[i].v;
            saw       = 0;
            step();
            saw |= rrst;
            sig_valid = 1'b0;
            repeat (RL + HL + 1) begin
                step();
                saw |= rrst;
            end
            chk("len_tbl", 32'(saw), 32'(tbl[i].exp));
        end

        // DC check: both channels biased.
        max_th = 16'd0;
        mask   = 2'b11;
        dc_th  = 8'd14;
        dc_window(1'b0, 1'b0);
        chk("dc_fire", 32'(rrst), 32'd1);
        chk("dc_cause", 32'(cause), 32'b010);
        settle();
        // Channel 1 zero-mean: no pulse.
        saw = 0;
        dc_window(1'b1, 1'b0);
        saw |= rrst;
        repeat (4) begin
            step();
            saw |= rrst;
        end
        chk("dc_zero_mean", 32'(saw), 32'd0);
        // Only channel 0 masked: pulse.
        mask = 2'b01;
        dc_window(1'b1, 1'b0);
        chk("dc_mask", 32'(rrst), 32'd1);
        settle();

        // Length and DC together, then a dropped trigger in HOLDOFF.
        mask = 2'b11;
        dc_window(1'b0, 1'b1);
        chk("both_fire", 32'(rrst), 32'd1);
        chk("both_cause", 32'(cause), 32'b011);
        hold_cnt = m_cnt;
        repeat (RL + 4) step();
        slen      = 16'd1001;
        max_th    = 16'd1000;
        sig_valid = 1'b1;
        step();
        sig_valid = 1'b0;
        repeat (3) step();
        chk("hold_drop_rst", 32'(rrst), 32'd0);
        chk("hold_drop_cnt", 32'(cnt), 32'(hold_cnt));
        settle();

        // Busy timeout.
        mask   = '0;
        dc_th  = '0;
        max_th = '0;
        to_th  = 24'd500;
        busy   = 1'b1;
        saw    = 0;
        for (int i = 1; i <= 560; i++) begin
            step();
            if (i == 499) chk("to_early", 32'(rrst), 32'd0);
            saw |= rrst;
`ifdef RX_SUPERVISOR_TIMEOUT_EN
            if (i == 500) chk("to_fire", 32'(rrst), 32'd1);
            if (i == 500) chk("to_cause", 32'(cause), 32'b100);
`endif
        end
`ifndef RX_SUPERVISOR_TIMEOUT_EN
        chk("to_absent", 32'(saw), 32'd0);
`endif
        busy = 1'b0;
        settle();

        // Asynchronous reset on the third PULSE cycle.
        slen      = 16'd1001;
        max_th    = 16'd1000;
        sig_valid = 1'b1;
        step();
        sig_valid = 1'b0;
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_rst", 32'(rrst), 32'd0);
        chk("arst_cause", 32'(cause), 32'd0);
        chk("arst_count", 32'(cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) step();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (c % 20 == 0)
                for (int k = 0; k < NCH; k++) begin
                    bi[k] = $urandom_range(0, 100);
                    bq[k] = $urandom_range(0, 100);
                end
            if (c % 250 == 0) begin
                mask  = NCH'($urandom);
                dc_th = 8'($urandom_range(0, 17));
                to_th = 24'($urandom_range(0, 60));
            end
            for (int k = 0; k < NCH; k++) begin
                si[k] = ($urandom_range(0, 99) < bi[k])
                        ? $urandom_range(0, 32767) : -$urandom_range(1, 32768);
                sq[k] = ($urandom_range(0, 99) < bq[k])
                        ? $urandom_range(0, 32767) : -$urandom_range(1, 32768);
            end
            strobe    = ($urandom_range(0, 3) != 0);
            sig_valid = ($urandom_range(0, 59) == 0);
            slen      = 16'($urandom_range(900, 1100));
            max_th    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'd1000;
            if ($urandom_range(0, 39) == 0) busy = ~busy;
            step();
        end
        quiet();
        to_th = '0;
        settle();

        // Counter saturation from a preloaded 0xFFFE.
        @(negedge clk);
        force dut.rst_count = 16'hFFFE;
        m_cnt = 65534;
        step();
        @(negedge clk);
        release dut.rst_count;
        step();
        for (int r = 0; r < 2; r++) begin
            slen      = 16'd1001;
            max_th    = 16'd1000;
            sig_valid = 1'b1;
            step();
            sig_valid = 1'b0;
            chk("sat_rst", 32'(rrst), 32'd1);
            chk("sat_count", 32'(cnt), 32'hFFFF);
            settle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_supervisor.md
RX_SUPERVISOR -- requirements
Module: rx_supervisor

Interface
REQ-001 SHALL have parameter IQ_DATA_WIDTH, default 16: bits per I or Q component.
REQ-002 SHALL have parameter N_CH, default 2: antenna channels supervised, range 1..4.
REQ-003 SHALL have parameter WIN_LOG2, default 4: DC window of 2^WIN_LOG2 strobed samples, range 2..7.
REQ-004 SHALL have parameter RST_LEN, default 8: receiver_rst pulse length in cycles, minimum 1.
REQ-005 SHALL have parameter HOLDOFF_LEN, default 64: trigger-ignore cycles after a pulse, minimum 1.
REQ-006 SHALL have port s00_axi_aclk, input, 1 bit: the single clock.
REQ-007 SHALL have port s00_axi_aresetn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port sample_in, input, 2*IQ_DATA_WIDTH*N_CH bits: channel k occupies [k*2W +: 2W], with I in the upper half and Q in the lower half, both signed.
REQ-009 SHALL have port sample_in_strobe, input, 1 bit: all channels are valid this cycle.
REQ-010 SHALL have port ch_mask, input, N_CH bits: 1 = channel participates in the DC check.
REQ-011 SHALL have port demod_is_ongoing, input, 1 bit: the demodulator is busy.
REQ-012 SHALL have port sig_valid, input, 1 bit: one-cycle strobe, SIGNAL field decoded OK.
REQ-013 SHALL have port signal_len, input, 16 bits: decoded length, sampled only on sig_valid.
REQ-014 SHALL have port max_signal_len_th, input, 16 bits: length limit; 0 disables the length check.
REQ-015 SHALL have port dc_running_sum_th, input, 8 bits: DC limit; 0 disables the DC check.
REQ-016 SHALL have port demod_timeout_th, input, 24 bits: busy-cycle limit; 0 disables the timeout check.
REQ-017 SHALL have port receiver_rst, output, 1 bit: registered active-high reset to the receiver core.
REQ-018 SHALL have port rst_cause, output, 3 bits: latched cause, bit0 = length, bit1 = DC, bit2 = timeout.
REQ-019 SHALL have port rst_count, output, 16 bits: number of pulses issued, saturating at 0xFFFF.

Function
REQ-020 SHALL run a state machine with states IDLE, PULSE and HOLDOFF; triggers SHALL be evaluated only in IDLE.
REQ-021 Length trigger SHALL fire in the cycle where sig_valid=1, the threshold is nonzero and signal_len > max_signal_len_th (strictly greater).
REQ-022 DC check: while demod_is_ongoing=0, each sample_in_strobe SHALL add +1 to a per-channel accumulator for each component if that I (or Q) is >= 0, and -1 if it is negative.
REQ-023 Accumulators SHALL be signed with WIN_LOG2+2 bits each (separate I and Q per channel).
REQ-024 On the 2^WIN_LOG2-th strobe, a channel SHALL be flagged if |accI| >= th or |accQ| >= th.
REQ-025 The DC trigger SHALL fire when ch_mask is nonzero and every masked channel is flagged.
REQ-026 Accumulators and the window counter SHALL clear at each window end.
REQ-027 Accumulators and the window counter SHALL also clear in any cycle where demod_is_ongoing=1 or the state is not IDLE.
REQ-028 Timeout check: a 24-bit busy counter SHALL increment each cycle demod_is_ongoing=1 and clear when it is 0; the trigger SHALL fire when the counter equals a nonzero threshold.
REQ-029 On any trigger in IDLE, the next edge SHALL enter PULSE, set receiver_rst=1 and load rst_cause with the OR of all triggers firing that cycle.
REQ-030 That same edge SHALL increment rst_count, saturating at 0xFFFF.
REQ-031 Latency from trigger cycle to receiver_rst=1 SHALL be exactly 1 cycle.
REQ-032 receiver_rst SHALL stay high for exactly RST_LEN cycles, then the block SHALL enter HOLDOFF with receiver_rst=0.
REQ-033 HOLDOFF SHALL last exactly HOLDOFF_LEN cycles, then return to IDLE; the busy counter SHALL clear on PULSE entry.
REQ-034 Triggers arriving during PULSE or HOLDOFF SHALL be dropped and SHALL NOT extend either phase.
REQ-035 rst_cause SHALL hold its value until the next pulse.
REQ-036 A threshold change takes effect on the next compare; no input SHALL be registered before compare other than the state itself.

Reset
REQ-037 Asserting s00_axi_aresetn=0 at any time, including mid-PULSE, SHALL asynchronously force IDLE, receiver_rst=0, rst_cause=0, rst_count=0, and all accumulators and counters to 0.

Configuration
REQ-038 With macro RX_SUPERVISOR_TIMEOUT_EN defined, the timeout detector (REQ-028) SHALL be built.
REQ-039 Without RX_SUPERVISOR_TIMEOUT_EN, the busy counter SHALL be absent, demod_timeout_th SHALL be ignored, and rst_cause[2] SHALL be constant 0.

Verification
REQ-040 max_th=1000, sig_valid with signal_len=1001 -> receiver_rst high for 8 cycles starting 1 cycle later, rst_cause=001, rst_count=1; signal_len=1000 -> no pulse.
REQ-041 N_CH=2, mask=11, th=14, 16 strobes with I=+5 and Q=-3 on both channels -> pulse with cause=010; the same stimulus with channel 1 zero-mean alternating -> no pulse.
REQ-042 TIMEOUT_EN defined, timeout_th=500, busy held high -> receiver_rst rises 1 cycle after the 500th busy cycle, cause=100; with the macro undefined -> no pulse ever.
REQ-043 Length and DC triggers in the same cycle -> cause=011 and a single pulse; a second length trigger during HOLDOFF -> ignored, rst_count unchanged.
REQ-044 Reset asserted on cycle 3 of PULSE -> receiver_rst=0 immediately; after release, IDLE with rst_count=0.
REQ-045 Force 0xFFFF pulses -> rst_count stays at 0xFFFF.
